// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731-style I2C control-port responder.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_BYTE     = 3'd3,
        S_BYTE_ACK = 3'd4,
        S_IGNORE   = 3'd5
    } state_t;

    localparam logic [6:0] I2C_CODEC_ADDR = 7'h1A;
    localparam int         REG_ADDR_W     = 7;
    localparam int         REG_DATA_W     = 9;
    localparam int         REGFILE_DEPTH  = 16;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into i_clk and produces registered edge, START and STOP pulses.
`timescale 1ns/1ps
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic r_scl_m, r_scl_s, r_scl_p;
    logic r_sda_m, r_sda_s, r_sda_p;

    // Two-stage synchronizers, previous-value stage and registered event pulses; idle bus is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_m    <= 1'b1;
            r_scl_s    <= 1'b1;
            r_scl_p    <= 1'b1;
            r_sda_m    <= 1'b1;
            r_sda_s    <= 1'b1;
            r_sda_p    <= 1'b1;
            o_sda      <= 1'b1;
            o_scl_rise <= 1'b0;
            o_scl_fall <= 1'b0;
            o_start    <= 1'b0;
            o_stop     <= 1'b0;
        end else begin
            r_scl_m    <= i_scl;
            r_scl_s    <= r_scl_m;
            r_scl_p    <= r_scl_s;
            r_sda_m    <= i_sda;
            r_sda_s    <= r_sda_m;
            r_sda_p    <= r_sda_s;
            o_sda      <= r_sda_s;
            o_scl_rise <= r_scl_s & ~r_scl_p;
            o_scl_fall <= ~r_scl_s & r_scl_p;
            o_start    <= r_scl_s & r_scl_p & r_sda_p & ~r_sda_s;
            o_stop     <= r_scl_s & r_scl_p & ~r_sda_p & r_sda_s;
        end
    end

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only target decoding 3-byte codec control writes; optional shadow
// register file with read port when I2C_RESP_REGFILE_EN is defined.
`timescale 1ns/1ps
module i2c_codec_responder
    import i2c_pkg::*;
#(
    parameter logic [REG_ADDR_W-1:0] DEV_ADDR = I2C_CODEC_ADDR
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    inout  wire                   io_sdat,
    output logic                  o_wr_valid,
    output logic [REG_ADDR_W-1:0] o_reg_addr,
    output logic [REG_DATA_W-1:0] o_reg_data,
    output logic                  o_busy,
`ifdef I2C_RESP_REGFILE_EN
    input  logic [3:0]            i_rd_addr,
    output logic [REG_DATA_W-1:0] o_rd_data,
`endif
    output logic                  o_err
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_line_sync u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_sclk),
        .i_sda      (io_sdat),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t                r_state, w_nstate;
    logic [2:0]            r_bit_cnt, w_bit_cnt;
    logic [1:0]            r_byte_cnt, w_byte_cnt;
    logic [7:0]            r_shift, w_shift, r_byte1, w_byte1, w_byte_in;
    logic                  r_sda_oe, w_sda_oe, w_wr_fire, w_err_fire, w_addressed, w_busy;
    logic                  r_wr_valid, r_err, r_busy;
    logic [REG_ADDR_W-1:0] r_reg_addr, w_new_addr;
    logic [REG_DATA_W-1:0] r_reg_data, w_new_data;

    assign io_sdat     = r_sda_oe ? 1'b0 : 1'bz;
    assign w_byte_in   = {r_shift[6:0], w_sda};
    assign w_new_addr  = r_byte1[7:1];
    assign w_new_data  = {r_byte1[0], w_byte_in};
    assign w_addressed = (r_state == S_ADDR_ACK) || (r_state == S_BYTE) || (r_state == S_BYTE_ACK);
    assign w_busy      = (w_nstate == S_ADDR_ACK) || (w_nstate == S_BYTE) || (w_nstate == S_BYTE_ACK);
    assign o_wr_valid  = r_wr_valid;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_data  = r_reg_data;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

    // Next-state logic; bus conditions outrank data edges in the same cycle.
    always_comb begin
        w_nstate   = r_state;
        w_bit_cnt  = r_bit_cnt;
        w_byte_cnt = r_byte_cnt;
        w_shift    = r_shift;
        w_byte1    = r_byte1;
        w_sda_oe   = r_sda_oe;
        w_wr_fire  = 1'b0;
        w_err_fire = 1'b0;
        if (w_start || w_stop) begin
            w_nstate   = w_start ? S_ADDR : S_IDLE;
            w_bit_cnt  = 3'd0;
            w_byte_cnt = 2'd0;
            w_sda_oe   = 1'b0;
            w_err_fire = w_addressed && (r_byte_cnt != 2'd2);
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift   = w_byte_in;
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_nstate = ((r_shift[6:0] == DEV_ADDR) && !w_sda) ? S_ADDR_ACK : S_IGNORE;
                        end else begin
                            w_nstate = S_ADDR;
                        end
                    end else begin
                        w_nstate = S_ADDR;
                    end
                end
                S_ADDR_ACK, S_BYTE_ACK: begin
                    // First SCL fall starts the ACK, the next one ends it.
                    if (w_scl_fall) begin
                        w_sda_oe = !r_sda_oe;
                        w_nstate = r_sda_oe ? S_BYTE : r_state;
                    end else begin
                        w_nstate = r_state;
                    end
                end
                S_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift   = w_byte_in;
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt != 3'd7) begin
                            w_nstate = S_BYTE;
                        end else if (r_byte_cnt == 2'd2) begin
                            w_err_fire = 1'b1;
                            w_nstate   = S_IGNORE;
                        end else begin
                            w_byte_cnt = r_byte_cnt + 2'd1;
                            w_nstate   = S_BYTE_ACK;
                            if (r_byte_cnt == 2'd0) begin
                                w_byte1 = w_byte_in;
                            end else begin
                                w_wr_fire = 1'b1;
                            end
                        end
                    end else begin
                        w_nstate = S_BYTE;
                    end
                end
                S_IDLE:   w_nstate = S_IDLE;
                S_IGNORE: w_nstate = S_IGNORE;
                default:  w_nstate = S_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 2'd0;
            r_shift    <= 8'd0;
            r_byte1    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
        end else begin
            r_state    <= w_nstate;
            r_bit_cnt  <= w_bit_cnt;
            r_byte_cnt <= w_byte_cnt;
            r_shift    <= w_shift;
            r_byte1    <= w_byte1;
            r_sda_oe   <= w_sda_oe;
            r_wr_valid <= w_wr_fire;
            r_err      <= w_err_fire;
            r_busy     <= w_busy;
            if (w_wr_fire) begin
                r_reg_addr <= w_new_addr;
                r_reg_data <= w_new_data;
            end
        end
    end

`ifdef I2C_RESP_REGFILE_EN
    logic [REG_DATA_W-1:0] r_regfile [REGFILE_DEPTH];

    // Shadow register file; a write to register 0x0F clears every entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REGFILE_DEPTH; i++) r_regfile[i] <= '0;
            o_rd_data <= '0;
        end else begin
            if (w_wr_fire && (w_new_addr == 7'h0F)) begin
                for (int i = 0; i < REGFILE_DEPTH; i++) r_regfile[i] <= '0;
            end else if (w_wr_fire && (w_new_addr < 7'd16)) begin
                r_regfile[w_new_addr[3:0]] <= w_new_data;
            end
            o_rd_data <= r_regfile[i_rd_addr];
        end
    end
`endif

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed plus randomized bench for i2c_codec_responder with a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_codec_responder;
    import i2c_pkg::*;

    localparam int Q = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    logic       wr_valid, busy, err;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
`ifdef I2C_RESP_REGFILE_EN
    logic [3:0] rd_addr = 4'd0;
    logic [8:0] rd_data;
`endif

    always #5 clk = ~clk;

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sclk     (scl),
        .io_sdat    (sda),
        .o_wr_valid (wr_valid),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .o_busy     (busy),
`ifdef I2C_RESP_REGFILE_EN
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
`endif
        .o_err      (err)
    );

    int tests = 0;
    int fails = 0;
    int n_wr = 0;
    int n_err = 0;
    logic [6:0] mon_addr = 7'd0;
    logic [8:0] mon_data = 9'd0;

    // Model state: expected strobe/error counts, last write, register contents.
    int         exp_wr = 0;
    int         exp_err = 0;
    logic [6:0] exp_addr = 7'd0;
    logic [8:0] exp_data = 9'd0;
    logic [8:0] regs [16];

    always @(negedge clk) begin
        if (wr_valid) begin
            n_wr++;
            mon_addr = reg_addr;
            mon_data = reg_data;
        end
        if (err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_c();
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic stop_c();
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i]; #Q;
            scl = 1'b1;    #(2*Q);
            scl = 1'b0;    #Q;
        end
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        ack = (sda === 1'b0);
        #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic model_write(input logic [15:0] w);
        exp_wr++;
        exp_addr = w[15:9];
        exp_data = w[8:0];
        if (w[15:9] == 7'h0F) begin
            for (int i = 0; i < 16; i++) regs[i] = 9'd0;
        end else if (w[15:9] < 7'd16) begin
            regs[w[12:9]] = w[8:0];
        end
    endtask

    task automatic write_word(input logic [15:0] w, input bit do_stop, input string tag);
        bit a;
        start_c();
        send_byte(8'h34, a);    check({tag, " ack dev"}, 32'(a), 32'd1);
        send_byte(w[15:8], a);  check({tag, " ack b1"}, 32'(a), 32'd1);
        send_byte(w[7:0], a);   check({tag, " ack b2"}, 32'(a), 32'd1);
        model_write(w);
        if (do_stop) stop_c();
    endtask

    task automatic check_state(input string tag);
        check({tag, " wr count"}, 32'(n_wr), 32'(exp_wr));
        check({tag, " err count"}, 32'(n_err), 32'(exp_err));
        check({tag, " reg_addr"}, 32'(reg_addr), 32'(exp_addr));
        check({tag, " reg_data"}, 32'(reg_data), 32'(exp_data));
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    logic [15:0] init_seq [10];

    initial begin
        bit a;
        int kind;
        logic [6:0] ra;
        logic [8:0] rd;
        logic [7:0] bad;

        init_seq = '{16'h0097, 16'h0297, 16'h0479, 16'h0679, 16'h0812,
                     16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};
        for (int i = 0; i < 16; i++) regs[i] = 9'd0;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst wr_valid", 32'(wr_valid), 32'd0);
        check("rst reg_addr", 32'(reg_addr), 32'd0);
        check("rst reg_data", 32'(reg_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst sda released", 32'(sda), 32'd1);
        rst_n = 1'b1;
        #(4*Q);

        // Write to LLI
        write_word(16'h0097, 1'b0, "lli");
        check("lli busy before stop", 32'(busy), 32'd1);
        stop_c();
        check_state("lli");
        check("lli mon addr", 32'(mon_addr), 32'h00);
        check("lli mon data", 32'(mon_data), 32'h097);

        // Full init sequence
        for (int i = 0; i < 10; i++) begin
            write_word(init_seq[i], 1'b1, "init");
            check("init mon addr", 32'(mon_addr), 32'(exp_addr));
            check("init mon data", 32'(mon_data), 32'(exp_data));
        end
        check_state("init");
        check("init last addr", 32'(reg_addr), 32'h09);
        check("init last data", 32'(reg_data), 32'h001);

        // Wrong address
        start_c();
        send_byte(8'h36, a);
        check("wrong addr nack", 32'(a), 32'd0);
        check("wrong addr busy", 32'(busy), 32'd0);
        stop_c();
        check_state("wrong addr");

        // Early STOP after first data byte
        start_c();
        send_byte(8'h34, a); check("early ack dev", 32'(a), 32'd1);
        send_byte(8'h08, a); check("early ack b1", 32'(a), 32'd1);
        stop_c();
        exp_err++;
        check_state("early stop");

        // Extra byte
        write_word(16'h0C00, 1'b0, "extra");
        send_byte(8'hAA, a);
        check("extra 4th nack", 32'(a), 32'd0);
        exp_err++;
        stop_c();
        check_state("extra");

        // Randomized transactions
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 3);
            ra = 7'($urandom_range(0, 127));
            rd = 9'($urandom_range(0, 511));
            case (kind)
                0: write_word({ra, rd}, 1'b1, "rnd good");
                1: begin
                    bad = 8'($urandom_range(0, 255));
                    if (bad == 8'h34) bad = 8'h35;
                    start_c();
                    send_byte(bad, a);
                    check("rnd bad nack", 32'(a), 32'd0);
                    stop_c();
                end
                2: begin
                    start_c();
                    send_byte(8'h34, a); check("rnd early ack", 32'(a), 32'd1);
                    if ($urandom_range(0, 1) == 1) begin
                        send_byte({ra, rd[8]}, a); check("rnd early ack b1", 32'(a), 32'd1);
                    end
                    stop_c();
                    exp_err++;
                end
                default: begin
                    write_word({ra, rd}, 1'b0, "rnd rs1");
                    write_word({rd[6:0], ra, rd[8:7]}, 1'b1, "rnd rs2");
                end
            endcase
            check_state("rnd");
        end

`ifdef I2C_RESP_REGFILE_EN
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            @(posedge clk); #1;
            check("rf model", 32'(rd_data), 32'(regs[i]));
        end
        write_word(16'h0279, 1'b1, "rf wr");
        rd_addr = 4'd1;
        @(posedge clk); #1;
        check("rf read 1", 32'(rd_data), 32'h079);
        write_word({7'h0F, 9'h1FF}, 1'b1, "rf clr");
        @(posedge clk); #1;
        check("rf cleared 1", 32'(rd_data), 32'h000);
        rd_addr = 4'd15;
        @(posedge clk); #1;
        check("rf cleared 15", 32'(rd_data), 32'h000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
